e1rx_tribarb: RTL

Round-robin collector that merges the byte streams of NCH E1 receive framers into one tagged byte stream for the shared VC12 mapper, all on the 19.44 MHz system clock. Each framer presents a byte with a one-cycle `dovld` strobe. This block gives each channel a one-byte holding register and grants one channel per free output slot. It presents the granted byte with its channel number under a valid/ready handshake, and flags per-channel overruns.

---
 rtl/e1rx_tribarb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/e1rx_tribarb.sv
`default_nettype none
// ============================================================================
// Module   : e1rx_tribarb
// Purpose  : Round-robin collector merging NCH E1 framer byte streams into one
//            channel-tagged byte stream with valid/ready output and overruns.
// Revision : 1.0 - initial release
// ============================================================================
module e1rx_tribarb #(
    parameter int NCH = 21,
    parameter int WID = 8,
    parameter int CHW = 5
) (
    input  logic               clk19,
    input  logic               rst,
    input  logic [NCH*WID-1:0] din,
    input  logic [NCH-1:0]     dinvld,
    input  logic [NCH-1:0]     chen,
    output logic [WID-1:0]     odata,
    output logic [CHW-1:0]     ochid,
    output logic               ovld,
    input  logic               ordy,
    output logic [NCH-1:0]     ovf,
    input  logic [NCH-1:0]     ovfclr
);

    localparam logic [CHW-1:0] C_LAST = CHW'(NCH - 1);
    localparam logic [CHW-1:0] C_ONE  = CHW'(1);

    logic [WID-1:0] din_w [NCH];

    logic [WID-1:0] hdat_q [NCH];
    logic [WID-1:0] hdat_d [NCH];
    logic [NCH-1:0] hful_q, hful_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [WID-1:0] odata_q, odata_d;
    logic [CHW-1:0] ochid_q, ochid_d;
    logic           ovld_q, ovld_d;

    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt;
    logic [CHW-1:0] gidx;
    logic           gvld;
    logic           slot_free;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_unpack
            assign din_w[i] = din[i*WID +: WID];
        end
    endgenerate

    assign req       = hful_q & chen;
    assign slot_free = !ovld_q || ordy;

    // First requester at or above ptr, wrapping at NCH-1; ptr is kept < NCH.
    always_comb begin
        int             idx;
        logic [CHW-1:0] ix;
        gnt  = '0;
        gidx = '0;
        gvld = 1'b0;
        idx  = 0;
        ix   = '0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            ix = CHW'(idx);
            if (!gvld && slot_free && req[ix]) begin
                gvld = 1'b1;
                gidx = ix;
            end
        end
        if (gvld) begin
            gnt[gidx] = 1'b1;
        end
    end

    // Holding registers: a grant frees the slot in the same cycle a new byte lands.
    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            acc       = dinvld[i] & chen[i];
            hdat_d[i] = hdat_q[i];
            hful_d[i] = hful_q[i];
            ovf_d[i]  = ovf_q[i] & ~ovfclr[i];
            if (!chen[i]) begin
                hful_d[i] = 1'b0;
            end else if (acc && (!hful_q[i] || gnt[i])) begin
                hdat_d[i] = din_w[i];
                hful_d[i] = 1'b1;
            end else if (acc) begin
                ovf_d[i] = 1'b1;
            end else if (gnt[i]) begin
                hful_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        odata_d = odata_q;
        ochid_d = ochid_q;
        ovld_d  = ovld_q;
        ptr_d   = ptr_q;
        if (slot_free) begin
            if (gvld) begin
                odata_d = hdat_q[gidx];
                ochid_d = gidx;
                ovld_d  = 1'b1;
                ptr_d   = (gidx == C_LAST) ? '0 : gidx + C_ONE;
            end else begin
                ovld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk19 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                hdat_q[i] <= '0;
            end
            hful_q  <= '0;
            ovf_q   <= '0;
            ptr_q   <= '0;
            odata_q <= '0;
            ochid_q <= '0;
            ovld_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hdat_q[i] <= hdat_d[i];
            end
            hful_q  <= hful_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            odata_q <= odata_d;
            ochid_q <= ochid_d;
            ovld_q  <= ovld_d;
        end
    end

    assign odata = odata_q;
    assign ochid = ochid_q;
    assign ovld  = ovld_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire
